// File: rtl/addsub_acc_pipe.sv
// rtl/addsub_acc_pipe.sv - pipelined add/sub/accumulate unit with valid/ready handshake
//
// Purpose: accepts one arithmetic request per cycle (add, sub, accumulate,
// clear accumulator) and returns its result LAT cycles later, in order.
// Parameters: W   operand/result width
//             LAT number of registered pipeline stages (1..8)
//             SAT 0 = wrap-around, 1 = unsigned saturation
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready is combinational)
//   op, a, b            operation code and unsigned operands
//   out_valid, out_ready result handshake
//   y, ovf              result and carry/borrow flag (registered)
module addsub_acc_pipe #(
  parameter int W   = 16,
  parameter int LAT = 2,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam bit SAT_EN = (SAT != 0);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [W-1:0] acc;
  logic [W-1:0] acc_nxt;
  logic [W:0]   sum_ab;
  logic [W:0]   sum_acc;
  logic [W-1:0] diff;
  logic [W-1:0] res_y;
  logic         res_o;
  logic         accept;

  logic [LAT-1:0] vld_q;
  logic [W-1:0]   y_q [LAT];
  logic [LAT-1:0] o_q;

  // The whole pipeline freezes only when the last stage holds a result the
  // consumer has not taken; bubbles in earlier stages never cause a stall.
  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign sum_acc = {1'b0, acc} + {1'b0, a};
  assign diff    = a - b;

  always_comb begin
    res_y   = '0;
    res_o   = 1'b0;
    acc_nxt = acc;
    case (op)
      OP_ADD: begin
        res_o = sum_ab[W];
        res_y = (SAT_EN && res_o) ? '1 : sum_ab[W-1:0];
      end
      OP_SUB: begin
        res_o = (b > a);
        res_y = (SAT_EN && res_o) ? '0 : diff;
      end
      OP_ACC: begin
        res_o   = sum_acc[W];
        res_y   = (SAT_EN && res_o) ? '1 : sum_acc[W-1:0];
        acc_nxt = res_y;
      end
      OP_CLR: begin
        acc_nxt = '0;
      end
      default: begin
        res_y = '0;
      end
    endcase
  end

  // Accumulator updates at accept time so back-to-back accumulates chain
  // without waiting for the previous result to leave the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && op[1]) begin
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      o_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        y_q[i] <= '0;
      end
    end else if (in_ready) begin
      vld_q[0] <= accept;
      y_q[0]   <= res_y;
      o_q[0]   <= res_o;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        y_q[i]   <= y_q[i-1];
        o_q[i]   <= o_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign y         = y_q[LAT-1];
  assign ovf       = o_q[LAT-1];

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// tb/tb_addsub_acc_pipe.sv - self-checking bench for addsub_acc_pipe
module tb_addsub_acc_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] irdy;
  logic [3:0] ovld;
  logic [3:0] ordy;
  logic [3:0] ovfv;
  logic [7:0] yv [4];

  always #5 clk = ~clk;

  // dut0: W=8 LAT=2 SAT=0 (stalled randomly); dut1: SAT=1; dut2: LAT=1; dut3: LAT=8
  addsub_acc_pipe #(.W(8), .LAT(2), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]), .op(op), .a(a), .b(b),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .y(yv[0]), .ovf(ovfv[0]));
  addsub_acc_pipe #(.W(8), .LAT(2), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]), .op(op), .a(a), .b(b),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .y(yv[1]), .ovf(ovfv[1]));
  addsub_acc_pipe #(.W(8), .LAT(1), .SAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]), .op(op), .a(a), .b(b),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .y(yv[2]), .ovf(ovfv[2]));
  addsub_acc_pipe #(.W(8), .LAT(8), .SAT(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[3]), .op(op), .a(a), .b(b),
    .out_valid(ovld[3]), .out_ready(ordy[3]), .y(yv[3]), .ovf(ovfv[3]));

  typedef struct {
    int unsigned y;
    int unsigned o;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t        q [4][$];
  int unsigned acc_m [4];
  int          stalls [4];
  bit          seen [4];
  int          sat_of [4] = '{0, 1, 0, 0};
  int          lat_of [4] = '{2, 2, 1, 8};
  int          cyc;
  int          n_chk;
  int          n_err;
  bit          took0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference arithmetic on plain integers, straight from the operation rules.
  task automatic model(input int d, input int unsigned f_op, input int unsigned fa,
                       input int unsigned fb, output int unsigned ry, output int unsigned ro);
    int unsigned s;
    ry = 0;
    ro = 0;
    case (f_op)
      0: begin
        s  = fa + fb;
        ro = (s > 255) ? 1 : 0;
        ry = (ro == 1 && sat_of[d] == 1) ? 255 : s % 256;
      end
      1: begin
        ro = (fb > fa) ? 1 : 0;
        ry = (ro == 1 && sat_of[d] == 1) ? 0 : (fa + 256 - fb) % 256;
      end
      2: begin
        s  = acc_m[d] + fa;
        ro = (s > 255) ? 1 : 0;
        ry = (ro == 1 && sat_of[d] == 1) ? 255 : s % 256;
        acc_m[d] = ry;
      end
      default: begin
        acc_m[d] = 0;
      end
    endcase
  endtask

  task automatic clear_models();
    for (int d = 0; d < 4; d++) begin
      q[d].delete();
      acc_m[d]  = 0;
      stalls[d] = 0;
      seen[d]   = 1'b0;
    end
  endtask

  // Sample at the falling edge: check outputs, then record this cycle's
  // transfers and accepts so the model advances exactly with the handshakes.
  task automatic monitor();
    exp_t        e;
    logic        stall;
    int unsigned ry;
    int unsigned ro;
    took0 = 1'b0;
    for (int d = 0; d < 4; d++) begin
      stall = ovld[d] && !ordy[d];
      check($sformatf("in_ready[%0d]", d), irdy[d], !stall);
      if (ovld[d]) begin
        if (q[d].size() == 0) begin
          check($sformatf("spurious_valid[%0d]", d), 1, 0);
        end else begin
          e = q[d][0];
          if (!seen[d]) begin
            check($sformatf("latency[%0d]", d), cyc - e.cyc - (stalls[d] - e.stl), lat_of[d]);
            seen[d] = 1'b1;
          end
          check($sformatf("y[%0d]", d), yv[d], e.y);
          check($sformatf("ovf[%0d]", d), ovfv[d], e.o);
          if (ordy[d]) begin
            void'(q[d].pop_front());
            seen[d] = 1'b0;
          end
        end
      end
      if (stall) stalls[d]++;
      if (in_valid && irdy[d]) begin
        model(d, op, a, b, ry, ro);
        e.y   = ry;
        e.o   = ro;
        e.cyc = cyc;
        e.stl = stalls[d];
        q[d].push_back(e);
        if (d == 0) took0 = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    ordy     = 4'hf;
    for (int i = 0; i < 14; i++) cycle();
  endtask

  task automatic issue(input logic [1:0] f_op, input logic [7:0] fa, input logic [7:0] fb);
    in_valid = 1'b1;
    op       = f_op;
    a        = fa;
    b        = fb;
    cycle();
  endtask

  logic [1:0] t_op [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
  logic [7:0] t_a  [8] = '{8'd100, 8'd200, 8'd10, 8'd30, 8'd0, 8'd100, 8'd150, 8'd10};
  logic [7:0] t_b  [8] = '{8'd27, 8'd100, 8'd30, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0};

  initial begin
    int  sent;
    int  guard;
    bit  pending;
    n_chk    = 0;
    n_err    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = 2'd0;
    a        = 8'd0;
    b        = 8'd0;
    ordy     = 4'hf;
    clear_models();

    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_out_valid[%0d]", d), ovld[d], 0);
      check($sformatf("rst_y[%0d]", d), yv[d], 0);
      check($sformatf("rst_ovf[%0d]", d), ovfv[d], 0);
      check($sformatf("rst_in_ready[%0d]", d), irdy[d], 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table, back-to-back with the consumer always ready.
    for (int i = 0; i < 8; i++) issue(t_op[i], t_a[i], t_b[i]);
    drain();

    // Randomized stream; dut0 sees random backpressure, requester holds inputs.
    sent    = 0;
    guard   = 0;
    pending = 1'b0;
    while (sent < 300 && guard < 5000) begin
      if (!pending && ($urandom_range(0, 3) != 0)) begin
        pending = 1'b1;
        op      = 2'($urandom_range(0, 3));
        a       = 8'($urandom);
        b       = 8'($urandom);
      end
      in_valid = pending;
      ordy[0]  = 1'($urandom);
      cycle();
      if (took0) begin
        pending = 1'b0;
        sent++;
      end
      guard++;
    end
    check("stream_budget", guard < 5000, 1);
    drain();

    // Reset with two results in flight and acc = 50.
    issue(2'd3, 8'd0, 8'd0);
    issue(2'd2, 8'd50, 8'd0);
    drain();
    check("acc_pre_reset", dut0.acc, 50);
    ordy[0] = 1'b0;
    issue(2'd0, 8'd1, 8'd2);
    issue(2'd1, 8'd9, 8'd3);
    in_valid = 1'b0;
    check("inflight_valid", ovld[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("midrst_out_valid[%0d]", d), ovld[d], 0);
      check($sformatf("midrst_y[%0d]", d), yv[d], 0);
    end
    check("midrst_acc", dut0.acc, 0);
    clear_models();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy  = 4'hf;
    for (int i = 0; i < 4; i++) cycle();
    issue(2'd2, 8'd5, 8'd0);
    drain();

    for (int d = 0; d < 4; d++) check($sformatf("drained[%0d]", d), q[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
